// File: rtl/alu_pkg.sv
// Shared opcodes, parser states and header rules for the ALU frame front end.
// Imported by the UART-side frame parser.
package alu_pkg;

    localparam logic [7:0]  OP_ECHO   = 8'hEC;
    localparam logic [7:0]  OP_ADD    = 8'hA0;
    localparam logic [7:0]  OP_MUL    = 8'hA1;
    localparam logic [7:0]  OP_DIV    = 8'hA2;
    localparam logic [15:0] HDR_BYTES = 16'd4;

    typedef enum logic [2:0] {
        S_OPCODE,
        S_RSVD,
        S_LEN_LO,
        S_LEN_HI,
        S_PAYLOAD,
        S_DROP
    } state_t;

    // Arithmetic frames must carry a whole, nonempty set of 32-bit operands.
    function automatic logic hdr_ok(
        input logic [7:0]  op,
        input logic [15:0] len,
        input logic [15:0] max_len
    );
        logic echo;
        logic arith;
        logic len_ok;
        echo   = (op == OP_ECHO);
        arith  = (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
        len_ok = (len >= HDR_BYTES) && (len <= max_len);
        return len_ok &&
               (echo || (arith && (len > HDR_BYTES) && (len[1:0] == 2'b00)));
    endfunction

endpackage

// File: rtl/alu_frame_parser.sv
// Splits the uart_rx byte stream into ALU frame headers and packed
// little-endian payload words; malformed frames are swallowed with an error pulse.
module alu_frame_parser
    import alu_pkg::*;
#(
    parameter logic [15:0] MAX_LEN = 16'd1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        hdr_valid_o,
    output logic [7:0]  hdr_op_o,
    output logic [15:0] hdr_len_o,
    output logic [31:0] word_data_o,
    output logic [2:0]  word_bytes_o,
    output logic        word_last_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        err_o
);

    state_t      state;
    logic [7:0]  op_q;
    logic [7:0]  len_lo_q;
    logic [15:0] rem_q;
    logic [1:0]  lane_q;
    logic [31:0] buf_q;
    logic        rdy_q;

    logic        take;
    logic [15:0] len_w;
    logic [15:0] rem_nx;
    logic [31:0] buf_nx;
    logic        final_b;
    logic        word_done;
    logic        good;

    // One bubble per emitted word keeps the packer free of a skid buffer.
    assign in_ready_o = rdy_q & ~word_valid_o;
    assign take       = in_valid_i & in_ready_o;
    assign len_w      = {in_data_i, len_lo_q};
    assign rem_nx     = rem_q - 16'd1;
    assign final_b    = (rem_q == 16'd1);
    assign word_done  = (lane_q == 2'd3) || final_b;
    assign good       = hdr_ok(op_q, len_w, MAX_LEN);

    always_comb begin
        buf_nx = buf_q;
        buf_nx[{lane_q, 3'b000} +: 8] = in_data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= S_OPCODE;
            op_q         <= 8'd0;
            len_lo_q     <= 8'd0;
            rem_q        <= 16'd0;
            lane_q       <= 2'd0;
            buf_q        <= 32'd0;
            rdy_q        <= 1'b0;
            hdr_valid_o  <= 1'b0;
            hdr_op_o     <= 8'd0;
            hdr_len_o    <= 16'd0;
            word_data_o  <= 32'd0;
            word_bytes_o <= 3'd0;
            word_last_o  <= 1'b0;
            word_valid_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            rdy_q       <= 1'b1;
            hdr_valid_o <= 1'b0;
            err_o       <= 1'b0;
            if (word_valid_o && word_ready_i) begin
                word_valid_o <= 1'b0;
            end
            if (take) begin
                unique case (state)
                    S_OPCODE: begin
                        op_q  <= in_data_i;
                        state <= S_RSVD;
                    end
                    S_RSVD: begin
                        state <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        len_lo_q <= in_data_i;
                        state    <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        rem_q  <= len_w - HDR_BYTES;
                        lane_q <= 2'd0;
                        buf_q  <= 32'd0;
                        if (good) begin
                            hdr_valid_o <= 1'b1;
                            hdr_op_o    <= op_q;
                            hdr_len_o   <= len_w;
                            state <= (len_w == HDR_BYTES) ? S_OPCODE
                                                          : S_PAYLOAD;
                        end else begin
                            err_o <= 1'b1;
                            state <= (len_w > HDR_BYTES) ? S_DROP
                                                         : S_OPCODE;
                        end
                    end
                    S_PAYLOAD: begin
                        rem_q <= rem_nx;
                        if (word_done) begin
                            word_data_o  <= buf_nx;
                            word_bytes_o <= {1'b0, lane_q} + 3'd1;
                            word_last_o  <= final_b;
                            word_valid_o <= 1'b1;
                            buf_q        <= 32'd0;
                            lane_q       <= 2'd0;
                        end else begin
                            buf_q  <= buf_nx;
                            lane_q <= lane_q + 2'd1;
                        end
                        if (final_b) begin
                            state <= S_OPCODE;
                        end
                    end
                    S_DROP: begin
                        rem_q <= rem_nx;
                        if (final_b) begin
                            state <= S_OPCODE;
                        end
                    end
                    default: begin
                        state <= S_OPCODE;
                    end
                endcase
            end
        end
    end

endmodule
